// File: rtl/axi_dma_ctrl_regs.sv
// AXI4-Lite register block for an N_CH-channel DMA engine: per-channel SRC/DST/LEN,
// CTRL (START/IE) and STATUS (BUSY/DONE/ERR) words, plus a registered level interrupt.
module axi_dma_ctrl_regs #(
  parameter int N_CH               = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [N_CH*32-1:0]            ch_src,
  output logic [N_CH*32-1:0]            ch_dst,
  output logic [N_CH*32-1:0]            ch_len,
  output logic [N_CH-1:0]               ch_start,
  input  logic [N_CH-1:0]               ch_done,
  output logic                          irq
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  // The channel field spans every address bit above bit 5 so aliases such as 0x80 are rejected.
  localparam int UW = C_S_AXI_ADDR_WIDTH - 4;
  localparam logic [UW-1:0] NCH_V       = UW'(N_CH);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  logic                          aw_full_q, aw_full_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                          w_full_q, w_full_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic [N_CH-1:0][31:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [N_CH-1:0]       ie_q, ie_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N_CH-1:0]       start_pend_q, start_pend_d, ch_start_q;
  logic                  irq_q, irq_d;

  logic [UW-1:0]  wfield_s, rfield_s;
  logic [CHW-1:0] wch_s, rch_s;
  logic [2:0]     wword_s, rword_s;
  logic           wr_ok_s, rd_ok_s, commit_s, wr_en_s, aw_hs_s, w_hs_s, ar_hs_s;
  logic           unused_s;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  if (C_S_AXI_ADDR_WIDTH > 5) begin : g_field
    assign wfield_s = {1'b0, awaddr_q[C_S_AXI_ADDR_WIDTH-1:5]};
    assign rfield_s = {1'b0, S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5]};
  end else begin : g_nofield
    assign wfield_s = '0;
    assign rfield_s = '0;
  end

  assign wch_s    = wfield_s[CHW-1:0];
  assign rch_s    = rfield_s[CHW-1:0];
  assign wword_s  = awaddr_q[4:2];
  assign rword_s  = S_AXI_ARADDR[4:2];
  assign wr_ok_s  = (wfield_s < NCH_V) && (wword_s <= 3'd4);
  assign rd_ok_s  = (rfield_s < NCH_V) && (rword_s <= 3'd4);
  assign aw_hs_s  = S_AXI_AWVALID & awready_q;
  assign w_hs_s   = S_AXI_WVALID & wready_q;
  assign ar_hs_s  = S_AXI_ARVALID & arready_q;
  assign commit_s = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_en_s  = commit_s & wr_ok_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q[1:0], S_AXI_ARADDR[1:0]};

  // AW/W holding slots and the write response channel.
  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit_s) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs_s) begin
        aw_full_d = 1'b1;
        awaddr_d  = S_AXI_AWADDR;
      end else begin
        aw_full_d = aw_full_q;
      end
      if (w_hs_s) begin
        w_full_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end else begin
        w_full_d = w_full_q;
      end
      if (bvalid_q && S_AXI_BREADY) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
  end

  // Per-channel register updates; engine completion is applied last so its DONE set wins.
  always_comb begin
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    ie_d         = ie_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    start_pend_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en_s && (wch_s == CHW'(i))) begin
        case (wword_s)
          3'd0: src_d[i] = busy_q[i] ? src_q[i] : apply_strb(src_q[i], wdata_q, wstrb_q);
          3'd1: dst_d[i] = busy_q[i] ? dst_q[i] : apply_strb(dst_q[i], wdata_q, wstrb_q);
          3'd2: len_d[i] = busy_q[i] ? len_q[i] : apply_strb(len_q[i], wdata_q, wstrb_q);
          3'd3: begin
            if (wstrb_q[0]) begin
              ie_d[i] = wdata_q[1];
              if (wdata_q[0] && busy_q[i]) begin
                err_d[i] = 1'b1;
              end else if (wdata_q[0]) begin
                busy_d[i]       = 1'b1;
                done_d[i]       = 1'b0;
                start_pend_d[i] = 1'b1;
              end else begin
                start_pend_d[i] = 1'b0;
              end
            end else begin
              ie_d[i] = ie_q[i];
            end
          end
          3'd4: begin
            if (wstrb_q[0]) begin
              done_d[i] = done_q[i] & ~wdata_q[1];
              err_d[i]  = err_q[i] & ~wdata_q[2];
            end else begin
              done_d[i] = done_q[i];
            end
          end
          default: start_pend_d[i] = 1'b0;
        endcase
      end else begin
        start_pend_d[i] = 1'b0;
      end
      if (ch_done[i]) begin
        busy_d[i] = 1'b0;
        done_d[i] = 1'b1;
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
    irq_d = |(ie_q & (done_q | err_q));
  end

  // Read channel: data is captured from the current (pre-write) register state at AR handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (rd_ok_s) begin
        rresp_d = RESP_OKAY;
        case (rword_s)
          3'd0:    rdata_d = src_q[rch_s];
          3'd1:    rdata_d = dst_q[rch_s];
          3'd2:    rdata_d = len_q[rch_s];
          3'd3:    rdata_d = {30'd0, ie_q[rch_s], 1'b0};
          3'd4:    rdata_d = {29'd0, err_q[rch_s], done_q[rch_s], busy_q[rch_s]};
          default: rdata_d = 32'd0;
        endcase
      end else begin
        rresp_d = RESP_SLVERR;
        rdata_d = 32'd0;
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = ~rvalid_d;
  end

  // State registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q    <= 1'b0;
      awaddr_q     <= '0;
      w_full_q     <= 1'b0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      ie_q         <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      err_q        <= '0;
      start_pend_q <= '0;
      ch_start_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      aw_full_q    <= aw_full_d;
      awaddr_q     <= awaddr_d;
      w_full_q     <= w_full_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      ie_q         <= ie_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_pend_q <= start_pend_d;
      ch_start_q   <= start_pend_q;
      irq_q        <= irq_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ch_src        = src_q;
  assign ch_dst        = dst_q;
  assign ch_len        = len_q;
  assign ch_start      = ch_start_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_axi_dma_ctrl_regs.sv
// Directed bench for axi_dma_ctrl_regs: a vector table of single AXI accesses plus
// hand-written sequences for start/done/irq, W-before-AW ordering and mid-transaction reset.
module tb_axi_dma_ctrl_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   awaddr = 8'h00, araddr = 8'h00;
  logic [2:0]   awprot = 3'd0, arprot = 3'd0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = 32'd0;
  logic [3:0]   wstrb = 4'd0;
  logic         awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] ch_src, ch_dst, ch_len;
  logic [3:0]   ch_start;
  logic [3:0]   ch_done = 4'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, b_cnt = 0, b_cyc = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t vq[$];

  axi_dma_ctrl_regs #(.N_CH(4), .C_S_AXI_ADDR_WIDTH(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
    .ch_start(ch_start), .ch_done(ch_done), .irq(irq)
  );

  always #5 clk = ~clk;

  // Event monitor: counts start pulses on channel 0 and accepted write responses.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ch_start[0]) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (bvalid && bready) begin
      b_cnt <= b_cnt + 1;
      b_cyc <= cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_p, w_p, got;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    got = 1'b0; resp = 2'b11;
    for (int c = 0; c < 40; c++) begin
      aw_p = awvalid && awready;
      w_p  = wvalid && wready;
      @(negedge clk);
      if (aw_p) awvalid = 1'b0;
      if (w_p) wvalid = 1'b0;
      if (bvalid) begin
        resp = bresp;
        got  = 1'b1;
        break;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("write_bvalid_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_p, got;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    got = 1'b0; d = 32'hxxxx_xxxx; resp = 2'b11;
    for (int c = 0; c < 40; c++) begin
      ar_p = arvalid && arready;
      @(negedge clk);
      if (ar_p) arvalid = 1'b0;
      if (rvalid) begin
        d    = rdata;
        resp = rresp;
        got  = 1'b1;
        break;
      end
    end
    arvalid = 1'b0;
    chk("read_rvalid_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_done(input int ch);
    @(negedge clk);
    ch_done[ch] = 1'b1;
    @(negedge clk);
    ch_done[ch] = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          s0, b0;
  bit          got, aw_p, w_p;

  initial begin
    // addr, data, strb, expected resp, expected read data
    vq.push_back('{1'b1, 8'h40, 32'h1000_0040, 4'hF, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h40, 32'h0,         4'h0, 2'b00, 32'h1000_0040});
    vq.push_back('{1'b0, 8'h43, 32'h0,         4'h0, 2'b00, 32'h1000_0040});
    vq.push_back('{1'b1, 8'h24, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h24, 32'h0,         4'h0, 2'b00, 32'h00BB_00DD});
    vq.push_back('{1'b1, 8'h24, 32'h1122_3344, 4'hA, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h24, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD});
    vq.push_back('{1'b1, 8'h68, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h68, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF});
    vq.push_back('{1'b1, 8'h94, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0});
    vq.push_back('{1'b0, 8'h94, 32'h0,         4'h0, 2'b10, 32'h0});
    vq.push_back('{1'b1, 8'h80, 32'hCAFE_F00D, 4'hF, 2'b10, 32'h0});
    vq.push_back('{1'b0, 8'h80, 32'h0,         4'h0, 2'b10, 32'h0});
    vq.push_back('{1'b0, 8'h00, 32'h0,         4'h0, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h5C, 32'h0,         4'h0, 2'b10, 32'h0});
    vq.push_back('{1'b1, 8'h2C, 32'h0000_0002, 4'hE, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h2C, 32'h0,         4'h0, 2'b00, 32'h0});
    vq.push_back('{1'b1, 8'h2C, 32'h0000_0002, 4'h1, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h2C, 32'h0,         4'h0, 2'b00, 32'h0000_0002});
    vq.push_back('{1'b1, 8'h30, 32'h0000_0007, 4'hF, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h30, 32'h0,         4'h0, 2'b00, 32'h0});
    vq.push_back('{1'b1, 8'h2C, 32'h0000_0000, 4'h1, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h2C, 32'h0,         4'h0, 2'b00, 32'h0});
    vq.push_back('{1'b1, 8'h48, 32'h0000_0100, 4'h3, 2'b00, 32'h0});
    vq.push_back('{1'b0, 8'h48, 32'h0,         4'h0, 2'b00, 32'h0000_0100});

    settle(2);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    settle(1);
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_wready", {31'd0, wready}, 32'd1);
    chk("rel_arready", {31'd0, arready}, 32'd1);

    foreach (vq[k]) begin
      if (vq[k].wr) begin
        do_write(vq[k].addr, vq[k].data, vq[k].strb, rs);
        chk($sformatf("vec%0d_bresp", k), {30'd0, rs}, {30'd0, vq[k].resp});
      end else begin
        do_read(vq[k].addr, rd, rs);
        chk($sformatf("vec%0d_rresp", k), {30'd0, rs}, {30'd0, vq[k].resp});
        chk($sformatf("vec%0d_rdata", k), rd, vq[k].rdata);
      end
    end
    chk("port_src_ch2", ch_src[95:64], 32'h1000_0040);
    chk("port_dst_ch1", ch_dst[63:32], 32'h11BB_33DD);
    chk("port_len_ch3", ch_len[127:96], 32'hDEAD_BEEF);

    // Completion on an idle channel still reports DONE; W1C clears it.
    pulse_done(1);
    do_read(8'h30, rd, rs);
    chk("idle_done_status", rd, 32'h2);
    do_write(8'h30, 32'h2, 4'h1, rs);
    do_read(8'h30, rd, rs);
    chk("idle_done_w1c", rd, 32'h0);

    // W three cycles ahead of AW: one commit, one response.
    b0 = b_cnt;
    @(negedge clk);
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      w_p = wvalid && wready;
      @(negedge clk);
      if (w_p) begin wvalid = 1'b0; got = 1'b1; end
    end
    chk("early_w_accepted", {31'd0, got}, 32'd1);
    settle(3);
    chk("early_w_no_resp", b_cnt - b0, 32'd0);
    @(negedge clk);
    awaddr = 8'h60; awvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      aw_p = awvalid && awready;
      @(negedge clk);
      if (aw_p) begin awvalid = 1'b0; got = 1'b1; end
    end
    chk("late_aw_accepted", {31'd0, got}, 32'd1);
    settle(10);
    chk("early_w_one_resp", b_cnt - b0, 32'd1);
    do_read(8'h60, rd, rs);
    chk("early_w_data", rd, 32'h55);

    // Start ch0 with IE, complete it, then clear DONE.
    s0 = start_cnt;
    do_write(8'h0C, 32'h3, 4'h1, rs);
    settle(3);
    chk("start_pulse_count", start_cnt - s0, 32'd1);
    chk("start_pulse_timing", start_cyc - b_cyc, 32'd1);
    do_read(8'h10, rd, rs);
    chk("start_status", rd, 32'h1);
    chk("start_irq_low", {31'd0, irq}, 32'd0);
    pulse_done(0);
    #1;
    chk("done_irq_lag", {31'd0, irq}, 32'd0);
    settle(1);
    chk("done_irq_set", {31'd0, irq}, 32'd1);
    do_read(8'h10, rd, rs);
    chk("done_status", rd, 32'h2);
    do_write(8'h10, 32'h2, 4'h1, rs);
    #1;
    chk("w1c_irq_clear", {31'd0, irq}, 32'd0);

    // Restart, then START again while busy: error, no pulse, LEN locked.
    s0 = start_cnt;
    do_write(8'h0C, 32'h3, 4'h1, rs);
    settle(3);
    chk("restart_pulse", start_cnt - s0, 32'd1);
    s0 = start_cnt;
    do_write(8'h0C, 32'h3, 4'h1, rs);
    settle(3);
    chk("busy_start_no_pulse", start_cnt - s0, 32'd0);
    do_read(8'h10, rd, rs);
    chk("busy_start_status", rd, 32'h5);
    do_write(8'h08, 32'h0000_1234, 4'hF, rs);
    chk("busy_len_bresp", {30'd0, rs}, 32'd0);
    do_read(8'h08, rd, rs);
    chk("busy_len_unchanged", rd, 32'h0);
    chk("err_irq", {31'd0, irq}, 32'd1);

    // Reset with a write response pending.
    @(negedge clk);
    awaddr = 8'h44; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      aw_p = awvalid && awready;
      w_p  = wvalid && wready;
      @(negedge clk);
      if (aw_p) awvalid = 1'b0;
      if (w_p) wvalid = 1'b0;
      if (bvalid) begin got = 1'b1; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pend_bvalid", {31'd0, got}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd0);
    chk("mid_rst_wready", {31'd0, wready}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_dst", ch_dst[95:64], 32'h0);
    chk("mid_rst_len", ch_len[127:96], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bready = 1'b1;
    b0 = b_cnt;
    settle(1);
    chk("post_rst_awready", {31'd0, awready}, 32'd1);
    chk("post_rst_wready", {31'd0, wready}, 32'd1);
    chk("post_rst_arready", {31'd0, arready}, 32'd1);
    settle(5);
    chk("post_rst_no_bresp", b_cnt - b0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 5; w++) begin
        do_read(8'(c * 32 + w * 4), rd, rs);
        chk($sformatf("zero_ch%0d_w%0d", c, w), rd, 32'h0);
        chk($sformatf("zero_ch%0d_w%0d_resp", c, w), {30'd0, rs}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
